dsp_fe_lut_table_loader: RTL and testbench

Producer side of the DSP-FE ADC-calibration LUT configuration interface.
- Collects a full calibration table (2**INPUT_WIDTH entries of OUTPUT_WIDTH bits) over a valid/ready word stream into a shadow register.
- Presents the table as the flat `o_cfg_table` bus and pulses `o_cfg_mode_load` for a fixed number of cycles so the LUT lanes latch it.
- Sits between the calibration/scan controller and the per-lane LUT instances.

---
 rtl/dsp_fe_lut_pkg.sv | 31 +++
 rtl/dsp_fe_lut_table_loader_if.sv | 46 ++++
 rtl/dsp_fe_lut_ldr_csum.sv | 53 +++++
 rtl/dsp_fe_lut_table_loader.sv | 189 ++++++++++++++++++
 tb/tb_dsp_fe_lut_table_loader.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dsp_fe_lut_pkg.sv
// ============================================================================
// Package : dsp_fe_lut_pkg
// Purpose : Shared types and constants for the DSP-FE ADC-calibration LUT and
//           its table loader (state encoding, default widths, table width).
// Macro   : DSP_FE_LUT_LDR_CSUM_EN enables the CHECK state in the loader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dsp_fe_lut_pkg;

  localparam int LUT_INPUT_WIDTH  = 6;
  localparam int LUT_OUTPUT_WIDTH = 6;
  localparam int LUT_TABLE_WIDTH  = (2 ** LUT_INPUT_WIDTH) * LUT_OUTPUT_WIDTH;

  // CHECK is only entered when the checksum feature is compiled in.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_CHECK = 2'd2,
    ST_LOAD  = 2'd3
  } lut_ldr_state_e;

  // Flat table width for a given address/entry width.
  function automatic int lut_table_width(input int iw, input int ow);
    return (2 ** iw) * ow;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dsp_fe_lut_table_loader_if.sv
// ============================================================================
// Interface : dsp_fe_lut_table_loader_if
// Purpose   : Control and entry-stream bundle between the calibration/scan
//             controller (master) and the LUT table loader (slave).
// Signals   : i_start, i_abort  - transfer control
//             i_wr_vld/o_wr_rdy - entry handshake, i_wr_dat entry data
//             i_csum            - expected checksum (DSP_FE_LUT_LDR_CSUM_EN)
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dsp_fe_lut_table_loader_if
  import dsp_fe_lut_pkg::*;
#(
  parameter int OUTPUT_WIDTH = LUT_OUTPUT_WIDTH,
  parameter int CSUM_WIDTH   = 8
) ();

  logic                    i_start;
  logic                    i_abort;
  logic                    i_wr_vld;
  logic                    o_wr_rdy;
  logic [OUTPUT_WIDTH-1:0] i_wr_dat;
  logic [CSUM_WIDTH-1:0]   i_csum;

  modport master (
    output i_start,
    output i_abort,
    output i_wr_vld,
    output i_wr_dat,
    output i_csum,
    input  o_wr_rdy
  );

  modport slave (
    input  i_start,
    input  i_abort,
    input  i_wr_vld,
    input  i_wr_dat,
    input  i_csum,
    output o_wr_rdy
  );

endinterface

`default_nettype wire

// File: rtl/dsp_fe_lut_ldr_csum.sv
// ============================================================================
// Module  : dsp_fe_lut_ldr_csum
// Purpose : Running checksum of zero-extended table entries, modulo
//           2**CSUM_WIDTH, with a compare against an expected value.
// Ports   : i_clk, i_rst_n (async active-low)
//           i_clr      - restart the sum at zero
//           i_acc_en   - add i_dat to the sum
//           i_dat      - entry value
//           i_csum_exp - expected checksum
//           o_match    - running sum equals i_csum_exp
// Note    : only instantiated when DSP_FE_LUT_LDR_CSUM_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dsp_fe_lut_ldr_csum #(
  parameter int DATA_WIDTH = 6,
  parameter int CSUM_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clr,
  input  logic                  i_acc_en,
  input  logic [DATA_WIDTH-1:0] i_dat,
  input  logic [CSUM_WIDTH-1:0] i_csum_exp,
  output logic                  o_match
);

  logic [CSUM_WIDTH-1:0] r_sum;
  logic [CSUM_WIDTH-1:0] w_dat_ext;

  // Bits above CSUM_WIDTH cannot affect a modulo-2**CSUM_WIDTH sum.
  if (DATA_WIDTH >= CSUM_WIDTH) begin : g_trunc
    assign w_dat_ext = i_dat[CSUM_WIDTH-1:0];
  end else begin : g_zext
    assign w_dat_ext = {{(CSUM_WIDTH-DATA_WIDTH){1'b0}}, i_dat};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sum <= '0;
    end else if (i_clr) begin
      r_sum <= '0;
    end else if (i_acc_en) begin
      r_sum <= r_sum + w_dat_ext;
    end
  end

  assign o_match = (r_sum == i_csum_exp);

endmodule

`default_nettype wire

// File: rtl/dsp_fe_lut_table_loader.sv
// ============================================================================
// Module  : dsp_fe_lut_table_loader
// Purpose : Collects a 2**INPUT_WIDTH x OUTPUT_WIDTH calibration table from a
//           valid/ready entry stream into a shadow register, then strobes
//           o_cfg_mode_load for LOAD_CYCLES cycles so the LUT lanes latch it.
// Ports   : i_clk, i_rst_n    - clock, async active-low reset
//           wr_if (slave)     - start/abort, entry stream, expected checksum
//           o_cfg_mode_load   - load strobe to the LUTs
//           o_cfg_table       - flat table, entry 0 in the MSBs
//           o_busy            - not IDLE
//           o_done            - one-cycle pulse after a completed load
//           o_err             - sticky checksum mismatch
//           o_entry_cnt       - entries accepted in current/last transfer
// Macro   : DSP_FE_LUT_LDR_CSUM_EN adds a CHECK state comparing the running
//           entry sum with i_csum; without it o_err is tied low.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dsp_fe_lut_table_loader
  import dsp_fe_lut_pkg::*;
#(
  parameter int INPUT_WIDTH  = LUT_INPUT_WIDTH,
  parameter int OUTPUT_WIDTH = LUT_OUTPUT_WIDTH,
  parameter int LOAD_CYCLES  = 2,
  parameter int CSUM_WIDTH   = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  dsp_fe_lut_table_loader_if.slave wr_if,
  output logic                   o_cfg_mode_load,
  output logic [lut_table_width(INPUT_WIDTH, OUTPUT_WIDTH)-1:0] o_cfg_table,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err,
  output logic [INPUT_WIDTH:0]   o_entry_cnt
);

  localparam int c_DEPTH = 2 ** INPUT_WIDTH;
  localparam int c_TW    = lut_table_width(INPUT_WIDTH, OUTPUT_WIDTH);
  localparam int c_LCW   = $clog2(LOAD_CYCLES + 1);

  localparam logic [INPUT_WIDTH-1:0] c_LAST_IDX  = {INPUT_WIDTH{1'b1}};
  localparam logic [c_LCW-1:0]       c_LOAD_LAST = c_LCW'(LOAD_CYCLES - 1);

  lut_ldr_state_e          r_state;
  lut_ldr_state_e          w_state_nxt;
  logic [OUTPUT_WIDTH-1:0] r_shadow [c_DEPTH];
  logic [INPUT_WIDTH:0]    r_cnt;
  logic [c_LCW-1:0]        r_load_cnt;
  logic                    r_done;
  logic                    w_done_nxt;
  logic                    w_fill;
  logic                    w_wr_fire;
  logic                    w_last_entry;
  logic                    w_load_last;
  logic                    w_start_ok;

  assign w_fill       = (r_state == ST_FILL);
  // Abort wins over a same-cycle write: the beat is dropped, not stored.
  assign w_wr_fire    = w_fill && wr_if.i_wr_vld && !wr_if.i_abort;
  assign w_last_entry = w_wr_fire && (r_cnt[INPUT_WIDTH-1:0] == c_LAST_IDX);
  assign w_load_last  = (r_state == ST_LOAD) && (r_load_cnt == c_LOAD_LAST);
  assign w_start_ok   = (r_state == ST_IDLE) && wr_if.i_start;

`ifdef DSP_FE_LUT_LDR_CSUM_EN
  logic w_csum_match;
  logic w_err_set;
  logic r_err;

  dsp_fe_lut_ldr_csum #(
    .DATA_WIDTH (OUTPUT_WIDTH),
    .CSUM_WIDTH (CSUM_WIDTH)
  ) u_csum (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (w_start_ok),
    .i_acc_en   (w_wr_fire),
    .i_dat      (wr_if.i_wr_dat),
    .i_csum_exp (wr_if.i_csum),
    .o_match    (w_csum_match)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err <= 1'b0;
    end else if (w_start_ok) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  logic [CSUM_WIDTH-1:0] w_unused_csum;
  assign w_unused_csum = wr_if.i_csum;
  assign o_err         = 1'b0;
`endif

  // Next-state and strobe decode.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
`ifdef DSP_FE_LUT_LDR_CSUM_EN
    w_err_set   = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (wr_if.i_start) w_state_nxt = ST_FILL;
      end
      ST_FILL: begin
        if (wr_if.i_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_last_entry) begin
`ifdef DSP_FE_LUT_LDR_CSUM_EN
          w_state_nxt = ST_CHECK;
`else
          w_state_nxt = ST_LOAD;
`endif
        end
      end
      ST_CHECK: begin
`ifdef DSP_FE_LUT_LDR_CSUM_EN
        if (w_csum_match) begin
          w_state_nxt = ST_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
          w_err_set   = 1'b1;
        end
`else
        w_state_nxt = ST_IDLE;
`endif
      end
      ST_LOAD: begin
        if (w_load_last) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_load_cnt <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      if (w_start_ok) begin
        r_cnt <= '0;
      end else if (w_wr_fire) begin
        r_cnt <= r_cnt + (INPUT_WIDTH+1)'(1);
      end
      if (r_state == ST_LOAD) begin
        r_load_cnt <= r_load_cnt + c_LCW'(1);
      end else begin
        r_load_cnt <= '0;
      end
    end
  end

  // Shadow keeps partial contents after an abort; only reset clears it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < c_DEPTH; k++) r_shadow[k] <= '0;
    end else if (w_wr_fire) begin
      r_shadow[r_cnt[INPUT_WIDTH-1:0]] <= wr_if.i_wr_dat;
    end
  end

  // Entry 0 in the MSBs to match the LUT's left-to-right unpack.
  for (genvar k = 0; k < c_DEPTH; k++) begin : g_pack
    assign o_cfg_table[c_TW-1-k*OUTPUT_WIDTH -: OUTPUT_WIDTH] = r_shadow[k];
  end

  assign wr_if.o_wr_rdy  = w_fill;
  assign o_cfg_mode_load = (r_state == ST_LOAD);
  assign o_busy          = (r_state != ST_IDLE);
  assign o_done          = r_done;
  assign o_entry_cnt     = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_dsp_fe_lut_table_loader.sv
// ============================================================================
// Module  : tb_dsp_fe_lut_table_loader
// Purpose : Self-checking bench for dsp_fe_lut_table_loader. A table model
//           and cycle-stamp expectations derived from the transfer rules are
//           compared against monitored load/done/busy activity.
// Macro   : DSP_FE_LUT_LDR_CSUM_EN adds the checksum transfers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dsp_fe_lut_table_loader;
  import dsp_fe_lut_pkg::*;

  localparam int IW    = LUT_INPUT_WIDTH;
  localparam int OW    = LUT_OUTPUT_WIDTH;
  localparam int LC    = 2;
  localparam int CW    = 8;
  localparam int DEPTH = 2 ** IW;
  localparam int TW    = DEPTH * OW;
`ifdef DSP_FE_LUT_LDR_CSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load;
  logic [TW-1:0] tab;
  logic          busy;
  logic          done;
  logic          err;
  logic [IW:0]   cnt;

  dsp_fe_lut_table_loader_if #(.OUTPUT_WIDTH(OW), .CSUM_WIDTH(CW)) wr_if ();

  dsp_fe_lut_table_loader #(
    .INPUT_WIDTH  (IW),
    .OUTPUT_WIDTH (OW),
    .LOAD_CYCLES  (LC),
    .CSUM_WIDTH   (CW)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .wr_if           (wr_if.slave),
    .o_cfg_mode_load (load),
    .o_cfg_table     (tab),
    .o_busy          (busy),
    .o_done          (done),
    .o_err           (err),
    .o_entry_cnt     (cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Cycle stamps of observed activity, sampled mid-cycle.
  int load_q[$];
  int done_q[$];
  int busy_q[$];
  always @(negedge clk) begin
    if (load) load_q.push_back(cyc);
    if (done) done_q.push_back(cyc);
    if (busy) busy_q.push_back(cyc);
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [OW-1:0] m_tab [DEPTH];

  task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [TW-1:0] model_flat();
    logic [TW-1:0] f = '0;
    for (int k = 0; k < DEPTH; k++) f[TW-1-k*OW -: OW] = m_tab[k];
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 back-to-back 63-k, 1 vld every other cycle, 2 random, 3 all ones
  task automatic xfer(input int mode, input int abort_beat, input bit start_mid,
                      input bit rst_in_load, input bit csum_bad, input string tag);
    int k = 0;
    int guard = 0;
    int n_start;
    int last_acc = -1;
    int abort_cyc = -1;
    bit aborted = 1'b0;
    bit exp_fail;
    logic v;
    logic [OW-1:0] d;
    logic [CW-1:0] sum = '0;
    load_q.delete();
    done_q.delete();
    busy_q.delete();
    wr_if.i_start = 1'b1;
    n_start = cyc;
    tick();
    wr_if.i_start = 1'b0;
    while (k < DEPTH && guard < 1000 && !aborted) begin
      guard++;
      case (mode)
        0:       begin v = 1'b1;                         d = OW'(DEPTH - 1 - k); end
        1:       begin v = (guard % 2 == 1);             d = OW'($urandom);      end
        3:       begin v = 1'b1;                         d = OW'(1);             end
        default: begin v = ($urandom_range(0, 3) != 0);  d = OW'($urandom);      end
      endcase
      wr_if.i_wr_vld = v;
      wr_if.i_wr_dat = d;
      wr_if.i_abort  = v && (k == abort_beat);
      if (start_mid && k == 20) wr_if.i_start = 1'b1;
      @(negedge clk);
      if (guard == 1) chk({tag, "_rdy_fill"}, TW'(wr_if.o_wr_rdy), TW'(1));
      tick();
      wr_if.i_start = 1'b0;
      if (wr_if.i_abort) begin
        aborted   = 1'b1;
        abort_cyc = cyc - 1;
      end else if (v) begin
        m_tab[k] = d;
        sum      = sum + CW'(d);
        k++;
        last_acc = cyc - 1;
      end
      wr_if.i_abort  = 1'b0;
      wr_if.i_wr_vld = 1'b0;
    end
    if (!aborted && k < DEPTH) begin
      chk({tag, "_timeout_beats"}, TW'(k), TW'(DEPTH));
      return;
    end
    if (aborted) begin
      repeat (4) tick();
      @(negedge clk);
      chk({tag, "_abort_rdy"},   TW'(wr_if.o_wr_rdy), TW'(0));
      chk({tag, "_abort_cnt"},   TW'(cnt), TW'(abort_beat));
      chk({tag, "_abort_nload"}, TW'(load_q.size()), TW'(0));
      chk({tag, "_abort_ndone"}, TW'(done_q.size()), TW'(0));
      chk({tag, "_abort_bsize"}, TW'(busy_q.size()), TW'(abort_cyc - n_start));
      if (busy_q.size() > 0) chk({tag, "_abort_blast"}, TW'(busy_q[$]), TW'(abort_cyc));
      chk({tag, "_abort_table"}, tab, model_flat());
      tick();
      return;
    end
    // Expected checksum is presented for the CHECK cycle (ignored otherwise).
    wr_if.i_csum = sum ^ CW'(csum_bad);
    if (start_mid) begin
      wr_if.i_start = 1'b1;
      for (int i = 0; i <= CK; i++) tick();
      wr_if.i_start = 1'b0;
    end
    if (rst_in_load) begin
      while (cyc < last_acc + 2 + CK) tick();
      #2 rst_n = 1'b0;
      #1;
      chk({tag, "_rst_load"},  TW'(load), TW'(0));
      chk({tag, "_rst_busy"},  TW'(busy), TW'(0));
      chk({tag, "_rst_table"}, tab, '0);
      chk({tag, "_rst_cnt"},   TW'(cnt), TW'(0));
      chk({tag, "_rst_done"},  TW'(done), TW'(0));
      for (int i = 0; i < DEPTH; i++) m_tab[i] = '0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      return;
    end
    while (cyc < last_acc + LC + CK + 4) tick();
    exp_fail = (CK == 1) && csum_bad;
    chk({tag, "_table"}, tab, model_flat());
    chk({tag, "_cnt"},   TW'(cnt), TW'(DEPTH));
    chk({tag, "_err"},   TW'(err), TW'(exp_fail));
    if (mode == 0) chk({tag, "_lat_last"}, TW'(last_acc), TW'(n_start + DEPTH));
    if (busy_q.size() > 0) chk({tag, "_busy_first"}, TW'(busy_q[0]), TW'(n_start + 1));
    if (exp_fail) begin
      chk({tag, "_nload"}, TW'(load_q.size()), TW'(0));
      chk({tag, "_ndone"}, TW'(done_q.size()), TW'(0));
      if (busy_q.size() > 0) chk({tag, "_busy_last"}, TW'(busy_q[$]), TW'(last_acc + 1));
    end else begin
      chk({tag, "_load_len"}, TW'(load_q.size()), TW'(LC));
      if (load_q.size() > 0) begin
        chk({tag, "_load_first"}, TW'(load_q[0]), TW'(last_acc + 1 + CK));
        chk({tag, "_load_last"},  TW'(load_q[$]), TW'(last_acc + LC + CK));
      end
      chk({tag, "_done_n"}, TW'(done_q.size()), TW'(1));
      if (done_q.size() > 0) chk({tag, "_done_cyc"}, TW'(done_q[0]), TW'(last_acc + LC + CK + 1));
      if (busy_q.size() > 0) chk({tag, "_busy_last"}, TW'(busy_q[$]), TW'(last_acc + LC + CK));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wr_if.i_start  = 1'b0;
    wr_if.i_abort  = 1'b0;
    wr_if.i_wr_vld = 1'b0;
    wr_if.i_wr_dat = '0;
    wr_if.i_csum   = '0;
    for (int i = 0; i < DEPTH; i++) m_tab[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_load",  TW'(load), TW'(0));
    chk("reset_table", tab, '0);
    chk("reset_busy",  TW'(busy), TW'(0));
    chk("reset_done",  TW'(done), TW'(0));
    chk("reset_err",   TW'(err), TW'(0));
    chk("reset_cnt",   TW'(cnt), TW'(0));
    chk("reset_rdy",   TW'(wr_if.o_wr_rdy), TW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    xfer(0, -1, 1'b0, 1'b0, 1'b0, "b2b");
    chk("b2b_entry0_msb", TW'(tab[TW-1 -: OW]), TW'(DEPTH - 1));
    chk("b2b_entry63_lsb", TW'(tab[OW-1:0]), TW'(0));
    xfer(1, -1, 1'b0, 1'b0, 1'b0, "alt");
    xfer(2, -1, 1'b0, 1'b0, 1'b0, "rnd");
    xfer(2, 10, 1'b0, 1'b0, 1'b0, "abort");
    xfer(0, -1, 1'b1, 1'b0, 1'b0, "startign");
    xfer(2, -1, 1'b0, 1'b1, 1'b0, "rstload");
    @(negedge clk);
    chk("post_rst_busy", TW'(busy), TW'(0));
    xfer(2, -1, 1'b0, 1'b0, 1'b0, "after_rst");
`ifdef DSP_FE_LUT_LDR_CSUM_EN
    xfer(3, -1, 1'b0, 1'b0, 1'b1, "csum_bad");
    xfer(3, -1, 1'b0, 1'b0, 1'b0, "csum_ok");
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
